fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that produces the op_code/funct3/funct7 fields consumed by the control decoder
//  and consumes its branch outputs (pc_imm) plus the ALU zero flag to redirect the PC.
//  Holds the PC, issues one 32-bit read at a time over a valid/ready request channel, buffers one
//  instruction for decode, discards wrong-path fetches on a taken branch, and halts on an illegal op.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  mem_req_valid  out  1   read request valid
//  mem_req_ready  in   1   memory accepts request when valid&ready
//  mem_req_addr   out  32  word address of request (bits[1:0]=0)
//  mem_rsp_valid  in   1   read data valid (1-cycle pulse, >=1 cycle after accept)
//  mem_rsp_data   in   32  instruction word
//  ins_valid      out  1   held instruction valid to decode
//  ins_ready      in   1   decode consumes instruction when ins_valid&ins_ready
//  ins            out  32  held instruction word
//  ins_pc         out  32  address of held instruction
//  op_code        out  7   ins[6:0];  funct3 out 3 ins[14:12];  funct7 out 7 ins[31:25]
//  op_illegal     in   1   decoder illegal flag for the held instruction
//  br_valid       in   1   branch resolution valid this cycle
//  pc_imm         in   2   decoder branch code: [0]=branch, [1]=1 take on alu_zero, 0 take on !alu_zero
//  alu_zero       in   1   ALU result == 0
//  br_pc          in   32  PC of resolving branch
//  br_offset      in   32  sign-extended B-immediate
//  halted         out  1   sticky; fetch stopped after illegal instruction
//  misalign       out  1   1-cycle pulse: taken target had bits[1:0]!=0
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, state=REQ, kill=0, mem_req_valid=0, ins=32'h0000_0013 (NOP),
//   ins_pc=0, ins_valid=0, halted=0, misalign=0. mem_req_valid rises the first edge after rst_n deasserts.
//  States: REQ, WAIT, FULL, HALT.
//  REQ: mem_req_valid=1, mem_req_addr=pc. valid&ready -> WAIT. Addr may change only on redirect.
//  WAIT: mem_req_valid=0. mem_rsp_valid: if kill -> kill=0, REQ (data dropped); else ins<=data,
//   ins_pc<=pc, pc<=pc+4 (wraps mod 2^32), -> FULL. Responses outside WAIT are ignored.
//  FULL: ins_valid=1, ins stable. ins_valid&ins_ready: if op_illegal -> HALT, halted=1; else -> REQ.
//   Next request issues the cycle after consumption (one outstanding request max).
//  taken = br_valid & pc_imm[0] & (pc_imm[1] ? alu_zero : ~alu_zero); not in HALT.
//  target = (br_pc + br_offset) & ~32'h3; misalign=1 next cycle if sum[1:0]!=0.
//  On taken (any state except HALT), next edge: pc<=target and
//   REQ without accept -> stay REQ (addr=target next cycle);
//   REQ with accept same cycle -> WAIT, kill=1; WAIT -> kill=1 (rsp same cycle also dropped, -> REQ);
//   FULL -> REQ, held instruction dropped.
//  ins_valid is forced 0 combinationally while taken=1: no wrong-path handshake, so no halt that cycle.
//  HALT: all outputs frozen except ins_valid=0, mem_req_valid=0; exits only by reset.
//  Reset mid-transaction: state lost; a late mem_rsp_valid after reset arrives in REQ and is ignored.
//  Latency: accept-to-ins_valid = response delay + 1 cycle; ins_ready-to-next req = 1 cycle.
// TESTING
//  1 Release reset, ready=1, rsp 1 cycle later = 32'h0050_0093 -> ins_valid, ins_pc=0, op_code=7'h13,
//    funct3=0, funct7=0; after consume next mem_req_addr=32'h4.
//  2 Hold ins_ready=0 for 5 cycles in FULL -> ins/ins_pc stable, mem_req_valid=0 throughout.
//  3 In WAIT: br_valid=1, pc_imm=2'b11, alu_zero=1, br_pc=8, br_offset=-8 -> pending rsp dropped,
//    next mem_req_addr=0, no ins_valid for dropped word.
//  4 pc_imm=2'b01, alu_zero=1 (or pc_imm=2'b00) -> no redirect, fetch sequence unchanged;
//    br_offset=6 taken -> target=br_pc+4, misalign pulses 1 cycle.
//  5 Consume with op_illegal=1 -> halted=1, no further mem_req_valid, taken branches ignored.
//  6 Assert rst_n=0 mid-WAIT, send rsp after release -> ignored; first req addr=RESET_PC, ins=NOP.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single outstanding memory read.
// Holds the PC, buffers one instruction for the decoder, squashes wrong-path
// fetches when a branch resolves taken, and stops for good on an illegal op.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [6:0]  op_code,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic        op_illegal,
  input  logic        br_valid,
  input  logic [1:0]  pc_imm,
  input  logic        alu_zero,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        halted,
  output logic        misalign
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic        kill_q,     kill_d;
  logic [31:0] insWord_q,  insWord_d;
  logic [31:0] insPc_q,    insPc_d;
  logic        halted_q,   halted_d;
  logic        misalign_q, misalign_d;
  logic        started_q;

  logic        brCond;
  logic        brTaken;
  logic [31:0] brSum;
  logic [31:0] brTarget;
  logic        reqAccept;
  logic        insAccept;

  // Branch resolution: taken decision, word-aligned target and misalignment flag.
  always_comb begin
    brCond   = pc_imm[1] ? alu_zero : ~alu_zero;
    brTaken  = br_valid & pc_imm[0] & brCond & (state_q != ST_HALT);
    brSum    = br_pc + br_offset;
    brTarget = {brSum[31:2], 2'b00};
  end

  // Output decode; the request is held off for the first cycle out of reset,
  // and a taken branch suppresses the decode handshake on the wrong-path word.
  always_comb begin
    mem_req_valid = started_q & (state_q == ST_REQ);
    mem_req_addr  = pc_q;
    ins_valid     = (state_q == ST_FULL) & ~brTaken;
    ins           = insWord_q;
    ins_pc        = insPc_q;
    op_code       = insWord_q[6:0];
    funct3        = insWord_q[14:12];
    funct7        = insWord_q[31:25];
    halted        = halted_q;
    misalign      = misalign_q;
    reqAccept     = mem_req_valid & mem_req_ready;
    insAccept     = ins_valid & ins_ready;
  end

  // Next-state logic: fetch sequencing, redirect on taken branch, halt on illegal op.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    insWord_d  = insWord_q;
    insPc_d    = insPc_q;
    halted_d   = halted_q;
    misalign_d = brTaken & (brSum[1:0] != 2'b00);

    unique case (state_q)
      ST_REQ: begin
        if (reqAccept) begin
          state_d = ST_WAIT;
          kill_d  = brTaken;
        end
        if (brTaken) begin
          pc_d = brTarget;
        end
      end

      ST_WAIT: begin
        if (brTaken) begin
          pc_d = brTarget;
          if (mem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            insWord_d = mem_rsp_data;
            insPc_d   = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = ST_FULL;
          end
        end
      end

      ST_FULL: begin
        if (brTaken) begin
          pc_d    = brTarget;
          state_d = ST_REQ;
        end else if (insAccept) begin
          if (op_illegal) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            state_d  = ST_REQ;
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      insWord_q  <= NOP_WORD;
      insPc_q    <= 32'h0000_0000;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      insWord_q  <= insWord_d;
      insPc_q    <= insPc_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
      started_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        op_illegal;
  logic        br_valid;
  logic [1:0]  pc_imm;
  logic        alu_zero;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        halted;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .op_code      (op_code),
    .funct3       (funct3),
    .funct7       (funct7),
    .op_illegal   (op_illegal),
    .br_valid     (br_valid),
    .pc_imm       (pc_imm),
    .alu_zero     (alu_zero),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .halted       (halted),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rspv;
    logic [31:0] rdata;
    logic        insrdy;
    logic        eReqv;
    logic [31:0] eAddr;
    logic        eInsv;
    logic [31:0] eIns;
    logic [31:0] eInsPc;
  } vec_t;

  vec_t vecs [10];

  // reference model state (transaction level)
  logic [31:0] mPc, mIns, mInsPc;
  logic        mStarted, mOut, mDoomed, mHeld, mHalted, mMis;
  logic        pending;
  int unsigned delay;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    ins_ready     = 1'b0;
    op_illegal    = 1'b0;
    br_valid      = 1'b0;
    pc_imm        = 2'b00;
    alu_zero      = 1'b0;
    br_pc         = 32'h0;
    br_offset     = 32'h0;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] imm, input logic z,
                               input logic [31:0] bpc, input logic [31:0] off);
    br_valid  = v;
    pc_imm    = imm;
    alu_zero  = z;
    br_pc     = bpc;
    br_offset = off;
  endtask

  // leaves the bench at a falling edge with reset just released, before the first rising edge
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mIns = NOP; mInsPc = 32'h0;
    mStarted = 1'b0; mOut = 1'b0; mDoomed = 1'b0;
    mHeld = 1'b0; mHalted = 1'b0; mMis = 1'b0;
  endtask

  initial begin
    logic        taken, eReqv, eInsv, accept;
    logic [31:0] sum;
    logic [31:0] D;

    rst_n = 1'b1;
    clearInputs();
    D = 32'h0050_0093;

    // ready, rspv, rdata, insrdy | reqv, addr, insv, ins, ins_pc
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, NOP, 32'h0};
    vecs[2] = '{1'b0, 1'b1, D,     1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 1'b1, D,   32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, D,   32'h0};

    // basic fetch, stall in FULL, consume and next request
    doReset();
    for (int i = 0; i < 10; i++) begin
      mem_req_ready = vecs[i].ready;
      mem_rsp_valid = vecs[i].rspv;
      mem_rsp_data  = vecs[i].rdata;
      ins_ready     = vecs[i].insrdy;
      #1;
      checkOutput($sformatf("vec%0d.req_valid", i), mem_req_valid, vecs[i].eReqv);
      checkOutput($sformatf("vec%0d.req_addr", i), mem_req_addr, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d.ins_valid", i), ins_valid, vecs[i].eInsv);
      checkOutput($sformatf("vec%0d.ins", i), ins, vecs[i].eIns);
      checkOutput($sformatf("vec%0d.ins_pc", i), ins_pc, vecs[i].eInsPc);
      checkOutput($sformatf("vec%0d.op_code", i), op_code, {25'h0, vecs[i].eIns[6:0]});
      checkOutput($sformatf("vec%0d.funct3", i), funct3, {29'h0, vecs[i].eIns[14:12]});
      checkOutput($sformatf("vec%0d.funct7", i), funct7, {25'h0, vecs[i].eIns[31:25]});
      @(negedge clk);
    end
    checkOutput("t1.op_code_const", {25'h0, op_code}, 32'h13);

    // taken branch while waiting: pending response dropped, refetch at target
    doReset();
    mem_req_ready = 1'b1;
    #1; checkOutput("t3.reqv_pre", mem_req_valid, 1'b0);
    @(negedge clk);
    #1; checkOutput("t3.reqv", mem_req_valid, 1'b1);
    checkOutput("t3.addr0", mem_req_addr, 32'h0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h8, 32'hFFFF_FFF8);
    #1; checkOutput("t3.wait_reqv", mem_req_valid, 1'b0);
    checkOutput("t3.wait_insv", ins_valid, 1'b0);
    @(negedge clk);
    clearInputs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0093;
    #1; checkOutput("t3.kill_reqv", mem_req_valid, 1'b0);
    @(negedge clk);
    clearInputs();
    #1; checkOutput("t3.redir_reqv", mem_req_valid, 1'b1);
    checkOutput("t3.redir_addr", mem_req_addr, 32'h0);
    checkOutput("t3.redir_insv", ins_valid, 1'b0);
    @(negedge clk);
    #1; checkOutput("t3.after_insv", ins_valid, 1'b0);
    checkOutput("t3.after_ins", ins, NOP);

    // not-taken codes leave fetch alone; misaligned taken target
    doReset();
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h100, 32'd20);
    #1; checkOutput("t4.reqv", mem_req_valid, 1'b1);
    checkOutput("t4.addr_a", mem_req_addr, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h100, 32'd20);
    #1; checkOutput("t4.addr_b", mem_req_addr, 32'h0);
    checkOutput("t4.mis_b", misalign, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h40, 32'd6);
    #1; checkOutput("t4.addr_c", mem_req_addr, 32'h0);
    checkOutput("t4.mis_c", misalign, 1'b0);
    @(negedge clk);
    clearInputs();
    #1; checkOutput("t4.addr_tgt", mem_req_addr, 32'h44);
    checkOutput("t4.mis_pulse", misalign, 1'b1);
    checkOutput("t4.reqv_tgt", mem_req_valid, 1'b1);
    @(negedge clk);
    #1; checkOutput("t4.mis_clear", misalign, 1'b0);
    checkOutput("t4.addr_hold", mem_req_addr, 32'h44);

    // illegal instruction consumed: halt is sticky, branches ignored
    doReset();
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1; checkOutput("t5.reqv", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0; ins_ready = 1'b1; op_illegal = 1'b1;
    #1; checkOutput("t5.insv", ins_valid, 1'b1);
    checkOutput("t5.not_halted", halted, 1'b0);
    @(negedge clk);
    clearInputs();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; ins_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b1, 32'h100, 32'h2);
    #1; checkOutput("t5.halted", halted, 1'b1);
    checkOutput("t5.halt_reqv", mem_req_valid, 1'b0);
    checkOutput("t5.halt_insv", ins_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("t5.frozen%0d.reqv", i), mem_req_valid, 1'b0);
      checkOutput($sformatf("t5.frozen%0d.addr", i), mem_req_addr, 32'h4);
      checkOutput($sformatf("t5.frozen%0d.halted", i), halted, 1'b1);
      checkOutput($sformatf("t5.frozen%0d.mis", i), misalign, 1'b0);
      checkOutput($sformatf("t5.frozen%0d.insv", i), ins_valid, 1'b0);
    end

    // reset mid-WAIT, late response after release is ignored
    doReset();
    mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1; checkOutput("t6.rst_reqv", mem_req_valid, 1'b0);
    checkOutput("t6.rst_ins", ins, NOP);
    checkOutput("t6.rst_halted", halted, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEE3;
    #1; checkOutput("t6.late_reqv", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1; checkOutput("t6.reqv", mem_req_valid, 1'b1);
    checkOutput("t6.addr", mem_req_addr, RESET_PC);
    checkOutput("t6.insv", ins_valid, 1'b0);
    checkOutput("t6.ins", ins, NOP);
    checkOutput("t6.ins_pc", ins_pc, 32'h0);
    @(negedge clk);
    #1; checkOutput("t6.insv2", ins_valid, 1'b0);

    // randomized run against the reference model
    doReset();
    modelReset();
    pending = 1'b0;
    delay   = 0;
    for (int c = 0; c < 4000; c++) begin
      int off;
      rst_n         = ($urandom_range(0, 299) != 0);
      if (!rst_n) modelReset();
      mem_req_ready = 1'($urandom_range(0, 1));
      ins_ready     = 1'($urandom_range(0, 1));
      op_illegal    = ($urandom_range(0, 29) == 0);
      off           = int'($urandom_range(0, 64)) - 32;
      applyStimulus(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, 32'(off));
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      if (pending) begin
        if (delay == 0) begin
          mem_rsp_valid = 1'b1;
          pending       = 1'b0;
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        mem_rsp_valid = 1'b1;
      end

      #1;
      taken = !mHalted && br_valid && pc_imm[0] && (pc_imm[1] ? alu_zero : !alu_zero);
      eReqv = mStarted && !mOut && !mHeld && !mHalted;
      eInsv = mHeld && !taken;
      checkOutput($sformatf("rnd%0d.req_valid", c), mem_req_valid, eReqv);
      checkOutput($sformatf("rnd%0d.req_addr", c), mem_req_addr, mPc);
      checkOutput($sformatf("rnd%0d.ins_valid", c), ins_valid, eInsv);
      checkOutput($sformatf("rnd%0d.ins", c), ins, mIns);
      checkOutput($sformatf("rnd%0d.ins_pc", c), ins_pc, mInsPc);
      checkOutput($sformatf("rnd%0d.op_code", c), op_code, {25'h0, mIns[6:0]});
      checkOutput($sformatf("rnd%0d.halted", c), halted, mHalted);
      checkOutput($sformatf("rnd%0d.misalign", c), misalign, mMis);

      @(posedge clk);
      if (rst_n) begin
        accept = eReqv && mem_req_ready;
        sum    = br_pc + br_offset;
        if (!mHalted) begin
          if (mOut) begin
            if (mem_rsp_valid) begin
              mOut = 1'b0;
              if (!mDoomed && !taken) begin
                mHeld  = 1'b1;
                mIns   = mem_rsp_data;
                mInsPc = mPc;
                mPc    = mPc + 32'd4;
              end
              mDoomed = 1'b0;
            end else if (taken) begin
              mDoomed = 1'b1;
            end
          end else if (mHeld) begin
            if (taken) begin
              mHeld = 1'b0;
            end else if (ins_ready) begin
              mHeld = 1'b0;
              if (op_illegal) mHalted = 1'b1;
            end
          end else if (accept) begin
            mOut    = 1'b1;
            mDoomed = taken;
            pending = 1'b1;
            delay   = $urandom_range(0, 2);
          end
          if (taken) mPc = {sum[31:2], 2'b00};
        end
        mMis     = taken && (sum[1:0] != 2'b00);
        mStarted = 1'b1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
